// File: rtl/pipe_ctrl_pkg.sv
// Shared constants and types for the pipeline stall/flush sequencer.
// Each output control vector is packed in this order: {pc_stall, if_id_stall, id_ex_stall, if_id_flush, id_ex_flush, ex_mem_bubble}.
package pipe_ctrl_pkg;

   localparam int REG_ADDR_WIDTH = 5;
   localparam int PCTL_ST_WIDTH  = 2;

   localparam logic [PCTL_ST_WIDTH-1:0] PCTL_RUN = 2'b00;
   localparam logic [PCTL_ST_WIDTH-1:0] PCTL_MCW = 2'b01;

   typedef struct packed {
      logic pc_stall;
      logic if_id_stall;
      logic id_ex_stall;
      logic if_id_flush;
      logic id_ex_flush;
      logic ex_mem_bubble;
   } pctl_ctl_t;

   localparam pctl_ctl_t CTL_NONE   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
   localparam pctl_ctl_t CTL_BRANCH = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
   localparam pctl_ctl_t CTL_MCHOLD = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
   localparam pctl_ctl_t CTL_LDUSE  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Combinational load-use comparator between the ID sources and the EX destination.
// The x0 destination never matches, so a load into x0 cannot cause a stall.
module hazard_detect
   import pipe_ctrl_pkg::*;
#(
   parameter int REG_AW = REG_ADDR_WIDTH
) (
   input  logic [REG_AW-1:0] id_rs1_addr_i,
   input  logic [REG_AW-1:0] id_rs2_addr_i,
   input  logic              id_rs1_used_i,
   input  logic              id_rs2_used_i,
   input  logic [REG_AW-1:0] ex_rd_addr_i,
   input  logic              ex_mem_read_i,
   output logic              lu_o
);

   logic rs1_hit;
   logic rs2_hit;

   assign rs1_hit = id_rs1_used_i & (id_rs1_addr_i == ex_rd_addr_i);
   assign rs2_hit = id_rs2_used_i & (id_rs2_addr_i == ex_rd_addr_i);
   assign lu_o    = ex_mem_read_i & (ex_rd_addr_i != '0) & (rs1_hit | rs2_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// Stall/flush sequencer: branch flush, multi-cycle EX hold with timeout abort,
// load-use bubble insertion, and saturating stall/flush performance counters.
//
// state | meaning
// RUN   | normal issue; hazards and branches resolved combinationally
// MCW   | waiting on a multi-cycle EX result, pipeline held
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int REG_AW     = REG_ADDR_WIDTH,
   parameter int CNT_W      = 32,
   parameter int MC_TIMEOUT = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [REG_AW-1:0] id_rs1_addr_i,
   input  logic [REG_AW-1:0] id_rs2_addr_i,
   input  logic              id_rs1_used_i,
   input  logic              id_rs2_used_i,
   input  logic [REG_AW-1:0] ex_rd_addr_i,
   input  logic              ex_mem_read_i,
   input  logic              ex_branch_taken_i,
   input  logic              ex_mc_start_i,
   input  logic              ex_mc_done_i,
   output logic              pc_stall_o,
   output logic              if_id_stall_o,
   output logic              id_ex_stall_o,
   output logic              if_id_flush_o,
   output logic              id_ex_flush_o,
   output logic              ex_mem_bubble_o,
   output logic              mc_err_o,
   output logic [CNT_W-1:0]  stall_cnt_o,
   output logic [CNT_W-1:0]  flush_cnt_o
);

   localparam int TMO_W = (MC_TIMEOUT > 2) ? $clog2(MC_TIMEOUT) : 1;
   // Abort on the edge that would bring the count to MC_TIMEOUT-1, so the
   // RUN start cycle plus the MCW cycles add up to exactly MC_TIMEOUT held cycles.
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MC_TIMEOUT - 2);

   logic [PCTL_ST_WIDTH-1:0] state_q;
   logic [PCTL_ST_WIDTH-1:0] state_d;
   logic [TMO_W-1:0]         tmo_cnt_q;
   logic                     mc_blk_q;
   logic                     mc_err_q;
   logic [CNT_W-1:0]         stall_cnt_q;
   logic [CNT_W-1:0]         flush_cnt_q;
   logic                     lu;
   logic                     mc_start;
   logic                     mc_hold;
   logic                     tmo_hit;
   logic                     enter_mcw;
   pctl_ctl_t                ctl;

   hazard_detect #(
      .REG_AW (REG_AW)
   ) u_hazard_detect (
      .id_rs1_addr_i (id_rs1_addr_i),
      .id_rs2_addr_i (id_rs2_addr_i),
      .id_rs1_used_i (id_rs1_used_i),
      .id_rs2_used_i (id_rs2_used_i),
      .ex_rd_addr_i  (ex_rd_addr_i),
      .ex_mem_read_i (ex_mem_read_i),
      .lu_o          (lu)
   );

   // After a timeout the same stuck op must not re-trigger until start drops.
   assign mc_start  = ex_mc_start_i & ~mc_blk_q;
   assign mc_hold   = ~ex_mc_done_i & (((state_q == PCTL_RUN) & mc_start) | (state_q == PCTL_MCW));
   assign tmo_hit   = (state_q == PCTL_MCW) & ~ex_mc_done_i & (tmo_cnt_q == TMO_LAST);
   assign enter_mcw = (state_q == PCTL_RUN) & mc_start & ~ex_mc_done_i & ~ex_branch_taken_i;

   always_comb begin
      ctl = CTL_NONE;
      if (rst)
         ctl = CTL_NONE;
      else if (ex_branch_taken_i)
         ctl = CTL_BRANCH;
      else if (mc_hold)
         ctl = CTL_MCHOLD;
      else if (lu)
         ctl = CTL_LDUSE;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         PCTL_RUN: if (enter_mcw) state_d = PCTL_MCW;
         PCTL_MCW: if (ex_mc_done_i || tmo_hit) state_d = PCTL_RUN;
         default:  state_d = PCTL_RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= PCTL_RUN;
         tmo_cnt_q   <= '0;
         mc_blk_q    <= 1'b0;
         mc_err_q    <= 1'b0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q <= state_d;
         if (enter_mcw)
            tmo_cnt_q <= '0;
         else if (state_q == PCTL_MCW)
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
         if (tmo_hit)
            mc_blk_q <= 1'b1;
         else if (!ex_mc_start_i)
            mc_blk_q <= 1'b0;
         if (tmo_hit)
            mc_err_q <= 1'b1;
         if (ctl.pc_stall && (stall_cnt_q != '1))
            stall_cnt_q <= stall_cnt_q + 1'b1;
         if (ex_branch_taken_i && (flush_cnt_q != '1))
            flush_cnt_q <= flush_cnt_q + 1'b1;
      end
   end

   assign pc_stall_o      = ctl.pc_stall;
   assign if_id_stall_o   = ctl.if_id_stall;
   assign id_ex_stall_o   = ctl.id_ex_stall;
   assign if_id_flush_o   = ctl.if_id_flush;
   assign id_ex_flush_o   = ctl.id_ex_flush;
   assign ex_mem_bubble_o = ctl.ex_mem_bubble;
   assign mc_err_o        = mc_err_q;
   assign stall_cnt_o     = stall_cnt_q;
   assign flush_cnt_o     = flush_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl with narrow counters and a short timeout.
// Expected vector layout: {pc_stall, if_id_stall, id_ex_stall, if_id_flush, id_ex_flush, ex_mem_bubble, mc_err, stall_cnt[3:0], flush_cnt[3:0]}.
module tb_pipe_ctrl;

   localparam logic [5:0] E_NONE = 6'b000000;
   localparam logic [5:0] E_BR   = 6'b000110;
   localparam logic [5:0] E_MC   = 6'b111001;
   localparam logic [5:0] E_LU   = 6'b110010;

   typedef struct {
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic [4:0] rd;
      logic       u1;
      logic       u2;
      logic       mr;
      logic       br;
      logic       st;
      logic       dn;
      logic       rs;
      logic [5:0] ctl;
   } stim_t;

   logic       clk;
   logic       rst;
   logic [4:0] id_rs1_addr_i, id_rs2_addr_i, ex_rd_addr_i;
   logic       id_rs1_used_i, id_rs2_used_i, ex_mem_read_i;
   logic       ex_branch_taken_i, ex_mc_start_i, ex_mc_done_i;
   logic       pc_stall_o, if_id_stall_o, id_ex_stall_o;
   logic       if_id_flush_o, id_ex_flush_o, ex_mem_bubble_o, mc_err_o;
   logic [3:0] stall_cnt_o, flush_cnt_o;

   logic [14:0] exp_q[$];
   logic [14:0] exp_v, obs_v;
   logic [3:0]  m_sc, m_fc;
   logic        m_err;
   int          n_cmp, n_bad;

   pipe_ctrl #(
      .REG_AW     (5),
      .CNT_W      (4),
      .MC_TIMEOUT (8)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .id_rs1_addr_i     (id_rs1_addr_i),
      .id_rs2_addr_i     (id_rs2_addr_i),
      .id_rs1_used_i     (id_rs1_used_i),
      .id_rs2_used_i     (id_rs2_used_i),
      .ex_rd_addr_i      (ex_rd_addr_i),
      .ex_mem_read_i     (ex_mem_read_i),
      .ex_branch_taken_i (ex_branch_taken_i),
      .ex_mc_start_i     (ex_mc_start_i),
      .ex_mc_done_i      (ex_mc_done_i),
      .pc_stall_o        (pc_stall_o),
      .if_id_stall_o     (if_id_stall_o),
      .id_ex_stall_o     (id_ex_stall_o),
      .if_id_flush_o     (if_id_flush_o),
      .id_ex_flush_o     (id_ex_flush_o),
      .ex_mem_bubble_o   (ex_mem_bubble_o),
      .mc_err_o          (mc_err_o),
      .stall_cnt_o       (stall_cnt_o),
      .flush_cnt_o       (flush_cnt_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic stim_t s(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                               input logic u1, input logic u2, input logic mr, input logic br,
                               input logic st, input logic dn, input logic rs, input logic [5:0] ctl);
      stim_t r;
      r.rs1 = rs1; r.rs2 = rs2; r.rd = rd; r.u1 = u1; r.u2 = u2; r.mr = mr;
      r.br = br; r.st = st; r.dn = dn; r.rs = rs; r.ctl = ctl;
      return r;
   endfunction

   function automatic logic [14:0] observe();
      return {pc_stall_o, if_id_stall_o, id_ex_stall_o, if_id_flush_o, id_ex_flush_o,
              ex_mem_bubble_o, mc_err_o, stall_cnt_o, flush_cnt_o};
   endfunction

   // Drive one cycle after the active edge, push its expectation, then update the model.
   task automatic drive(input stim_t t);
      @(posedge clk);
      #1;
      id_rs1_addr_i = t.rs1; id_rs2_addr_i = t.rs2; ex_rd_addr_i = t.rd;
      id_rs1_used_i = t.u1;  id_rs2_used_i = t.u2;  ex_mem_read_i = t.mr;
      ex_branch_taken_i = t.br; ex_mc_start_i = t.st; ex_mc_done_i = t.dn; rst = t.rs;
      exp_q.push_back({t.ctl, m_err, m_sc, m_fc});
      @(negedge clk);
      if (t.rs) begin
         m_sc = '0; m_fc = '0; m_err = 1'b0;
      end else begin
         if (t.ctl[5] && m_sc != 4'hf) m_sc = m_sc + 4'd1;
         if (t.br && m_fc != 4'hf) m_fc = m_fc + 4'd1;
      end
   endtask

   task automatic test_reset();
      stim_t t[3];
      rst = 1'b1;
      id_rs1_addr_i = '0; id_rs2_addr_i = '0; ex_rd_addr_i = '0;
      id_rs1_used_i = 0; id_rs2_used_i = 0; ex_mem_read_i = 0;
      ex_branch_taken_i = 0; ex_mc_start_i = 0; ex_mc_done_i = 0;
      repeat (2) @(posedge clk);
      t[0] = s(5'd5, 5'd0, 5'd5, 1, 0, 1, 0, 0, 0, 1, E_NONE);
      t[1] = s(5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, 0, 1, E_NONE);
      t[2] = s(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, 0, 1, E_NONE);
      for (int i = 0; i < 3; i++) begin
         drive(t[i]);
         exp_v = exp_q.pop_front(); obs_v = observe(); n_cmp++;
         if (obs_v !== exp_v) begin
            n_bad++; $display("FAIL reset[%0d]: got %b want %b", i, obs_v, exp_v);
         end
      end
   endtask

   task automatic test_load_use();
      stim_t t[6];
      t[0] = s(5'd5, 5'd0, 5'd5, 1, 0, 1, 0, 0, 0, 0, E_LU);
      t[1] = s(5'd5, 5'd0, 5'd5, 1, 0, 0, 0, 0, 0, 0, E_NONE);
      t[2] = s(5'd0, 5'd0, 5'd0, 1, 1, 1, 0, 0, 0, 0, E_NONE);
      t[3] = s(5'd3, 5'd7, 5'd7, 1, 1, 1, 0, 0, 0, 0, E_LU);
      t[4] = s(5'd7, 5'd2, 5'd7, 0, 1, 1, 0, 0, 0, 0, E_NONE);
      t[5] = s(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, 0, E_NONE);
      for (int i = 0; i < 6; i++) begin
         drive(t[i]);
         exp_v = exp_q.pop_front(); obs_v = observe(); n_cmp++;
         if (obs_v !== exp_v) begin
            n_bad++; $display("FAIL load_use[%0d]: got %b want %b", i, obs_v, exp_v);
         end
      end
   endtask

   task automatic test_branch();
      stim_t t[4];
      t[0] = s(5'd9, 5'd0, 5'd9, 1, 0, 1, 1, 0, 0, 0, E_BR);
      t[1] = s(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, 0, E_NONE);
      t[2] = s(5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 1, 0, 0, E_BR);
      t[3] = s(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, 0, E_NONE);
      for (int i = 0; i < 4; i++) begin
         drive(t[i]);
         exp_v = exp_q.pop_front(); obs_v = observe(); n_cmp++;
         if (obs_v !== exp_v) begin
            n_bad++; $display("FAIL branch[%0d]: got %b want %b", i, obs_v, exp_v);
         end
      end
   endtask

   task automatic test_multicycle();
      stim_t t[6];
      t[0] = s(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, 0, 0, E_MC);
      t[1] = s(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, 0, 0, E_MC);
      t[2] = s(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, 0, 0, E_MC);
      t[3] = s(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, 1, 0, E_NONE);
      t[4] = s(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, 1, 0, E_NONE);
      t[5] = s(5'd4, 5'd0, 5'd4, 1, 0, 1, 0, 0, 0, 0, E_LU);
      for (int i = 0; i < 6; i++) begin
         drive(t[i]);
         exp_v = exp_q.pop_front(); obs_v = observe(); n_cmp++;
         if (obs_v !== exp_v) begin
            n_bad++; $display("FAIL multicycle[%0d]: got %b want %b", i, obs_v, exp_v);
         end
      end
   endtask

   task automatic test_timeout();
      stim_t t[15];
      for (int i = 0; i < 8; i++) t[i] = s(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, 0, 0, E_MC);
      t[8]  = s(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, 0, 0, E_NONE);
      t[9]  = s(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, 0, 0, E_NONE);
      t[10] = s(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, 0, E_NONE);
      t[11] = s(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, 0, 0, E_MC);
      t[12] = s(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, 0, 0, E_MC);
      t[13] = s(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, 1, 0, E_NONE);
      t[14] = s(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, 0, E_NONE);
      for (int i = 0; i < 15; i++) begin
         if (i == 8) m_err = 1'b1;
         drive(t[i]);
         exp_v = exp_q.pop_front(); obs_v = observe(); n_cmp++;
         if (obs_v !== exp_v) begin
            n_bad++; $display("FAIL timeout[%0d]: got %b want %b", i, obs_v, exp_v);
         end
      end
   endtask

   task automatic test_reset_mid_mcw();
      stim_t t[6];
      t[0] = s(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, 0, 0, E_MC);
      t[1] = s(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, 0, 0, E_MC);
      t[2] = s(5'd6, 5'd0, 5'd6, 1, 0, 1, 0, 1, 0, 1, E_NONE);
      t[3] = s(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, 0, E_NONE);
      t[4] = s(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, 1, 0, E_NONE);
      t[5] = s(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, 0, E_NONE);
      for (int i = 0; i < 6; i++) begin
         drive(t[i]);
         exp_v = exp_q.pop_front(); obs_v = observe(); n_cmp++;
         if (obs_v !== exp_v) begin
            n_bad++; $display("FAIL reset_mid_mcw[%0d]: got %b want %b", i, obs_v, exp_v);
         end
      end
   endtask

   task automatic test_saturation();
      stim_t t;
      for (int i = 0; i < 44; i++) begin
         if (i < 20)      t = s(5'd8, 5'd0, 5'd8, 1, 0, 1, 0, 0, 0, 0, E_LU);
         else if (i < 22) t = s(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, 0, E_NONE);
         else if (i < 42) t = s(5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, 0, 0, E_BR);
         else             t = s(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, 0, E_NONE);
         drive(t);
         exp_v = exp_q.pop_front(); obs_v = observe(); n_cmp++;
         if (obs_v !== exp_v) begin
            n_bad++; $display("FAIL saturation[%0d]: got %b want %b", i, obs_v, exp_v);
         end
      end
   endtask

   initial begin
      n_cmp = 0; n_bad = 0;
      m_sc = '0; m_fc = '0; m_err = 1'b0;
      test_reset();
      test_load_use();
      test_branch();
      test_multicycle();
      test_timeout();
      test_reset_mid_mcw();
      test_saturation();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central stall/flush sequencer for the five-stage pipeline. It sits beside the ID/EX datapath, including the immediate-extension path.
- Detects load-use hazards and applies taken-branch flushes.
- Holds the pipeline while a multi-cycle EX operation (mul/div) runs, with a timeout guard.
- Keeps saturating stall and flush performance counters.

Parameters:
- REG_AW, 5, register address width (`REG_ADDR_WIDTH).
- CNT_W, 32, performance counter width.
- MC_TIMEOUT, 64, maximum multi-cycle wait in cycles before error abort (>=2).

Ports:
- clk  input  1  pipeline clock
- rst  input  1  reset: synchronous, active-high
- id_rs1_addr_i  input  REG_AW  rs1 index of instruction in ID
- id_rs2_addr_i  input  REG_AW  rs2 index of instruction in ID
- id_rs1_used_i  input  1  ID instruction reads rs1
- id_rs2_used_i  input  1  ID instruction reads rs2
- ex_rd_addr_i  input  REG_AW  rd index of instruction in EX
- ex_mem_read_i  input  1  EX instruction is a load
- ex_branch_taken_i  input  1  EX resolved a taken branch/jump (redirect)
- ex_mc_start_i  input  1  EX holds a multi-cycle op (level, held while op sits in EX)
- ex_mc_done_i  input  1  multi-cycle result valid this cycle
- pc_stall_o  output  1  hold PC
- if_id_stall_o  output  1  hold IF/ID register
- id_ex_stall_o  output  1  hold ID/EX register
- if_id_flush_o  output  1  clear IF/ID to NOP
- id_ex_flush_o  output  1  clear ID/EX to NOP (bubble)
- ex_mem_bubble_o  output  1  write NOP into EX/MEM
- mc_err_o  output  1  sticky multi-cycle timeout flag
- stall_cnt_o  output  CNT_W  cycles with pc_stall_o=1
- flush_cnt_o  output  CNT_W  taken-branch flush events

Behaviour:
- FSM states: RUN (2'b00), MCW (2'b01). Encodings are `PCTL_RUN and `PCTL_MCW.
- Reset (rst=1 at a clock edge):
  - state→RUN, mc_err_o=0, both counters 0, timeout counter 0.
  - While rst=1, all stall/flush/bubble outputs are forced to 0.
  - Reset during MCW aborts the wait; RUN takes effect the next cycle.
- Load-use hazard: lu = ex_mem_read_i & (ex_rd_addr_i!=0) & ((id_rs1_used_i & rs1==rd) | (id_rs2_used_i & rs2==rd)).
- Multi-cycle hold: mc_hold = ~ex_mc_done_i & ((state==RUN & ex_mc_start_i) | state==MCW). Single-cycle completion (start and done in the same cycle) produces no stall.
- Output priority (combinational, same cycle):
  1. ex_branch_taken_i: if_id_flush_o=1, id_ex_flush_o=1, all stalls 0. The PC loads the target. lu is ignored because it is on the wrong path. A branch in RUN also suppresses an MC start; the FSM stays in RUN.
  2. mc_hold: pc/if_id/id_ex stall=1, ex_mem_bubble_o=1, no flushes.
  3. lu: pc_stall_o=1, if_id_stall_o=1, id_ex_flush_o=1. One bubble is inserted; the hazard clears next cycle when the load moves to MEM.
  4. Otherwise all 0.
- FSM transitions:
  - RUN→MCW when ex_mc_start_i & ~ex_mc_done_i & ~ex_branch_taken_i.
  - MCW→RUN when ex_mc_done_i. In that done cycle, stalls and bubble are already 0 so the result latches into EX/MEM.
  - MCW→RUN on timeout.
- Timeout:
  - The counter clears on RUN→MCW and increments each MCW cycle.
  - When it reaches MC_TIMEOUT-1 without done: mc_err_o←1 (sticky until rst), state→RUN.
  - A hold asserted on start stays in effect for at most MC_TIMEOUT cycles.
  - After the abort, ex_mc_start_i is ignored until it drops low for one cycle. This prevents an immediate re-hold.
- Counters:
  - stall_cnt_o +1 on every non-reset cycle with pc_stall_o=1.
  - flush_cnt_o +1 per cycle with ex_branch_taken_i=1.
  - Both saturate at all-ones and never wrap.
- ex_rd_addr_i==0 never causes a stall (x0).

Decomposition:
- riscv_define.v gains `REG_ADDR_WIDTH, `PCTL_RUN, `PCTL_MCW, `PCTL_ST_WIDTH.
- Sub-module hazard_detect: purely combinational load-use comparator producing lu. It is reusable for forwarding-unit checks.
- FSM, timeout, priority mux and counters stay in pipe_ctrl.

Test Plan:
- Load-use: ex_mem_read=1, rd=5; ID rs1=5 used → one cycle pc_stall=if_id_stall=id_ex_flush=1, then 0; stall_cnt=1. Same with rd=0 → no stall.
- Branch vs load-use: lu condition plus ex_branch_taken=1 → if_id_flush=id_ex_flush=1, pc_stall=0; flush_cnt=1.
- Multi-cycle: start held 4 cycles, done on the 4th → stalls+bubble high for 3 cycles, 0 in done cycle, state MCW→RUN; start with done same cycle → no stall.
- Timeout: MC_TIMEOUT=8, start held, done never → hold for 8 cycles, then mc_err_o=1, state RUN, no re-hold until start drops.
- Reset mid-MCW: rst pulse at cycle 2 of wait → outputs 0 during rst, state RUN, counters 0, mc_err_o 0.
- Saturation: CNT_W=4, 20 stall cycles → stall_cnt_o=15, stays 15.
